eval_accumulate: RTL and testbench

//  Nios II multi-cycle custom instruction that sits downstream of the per-element evaluator.
//  It sums the IEEE-754 single-precision f(x[i]) results into a running total, sum(f(x[i])).
//  A small input FIFO lets ACCUMULATE retire quickly; the adder drains the FIFO in the background.
//  The CPU reads the finished sum, or the element count, with READ opcodes.

---
 rtl/eval_pkg.sv | 24 ++
 rtl/eval_accumulate_if.sv | 11 +
 rtl/acc_fifo.sv | 44 ++++
 rtl/new_add.sv | 95 +++++++++
 rtl/eval_accumulate.sv | 127 ++++++++++++
 tb/tb_eval_accumulate.sv | 225 ++++++++++++++++++++++
 6 files changed

// File: rtl/eval_pkg.sv
// rtl/eval_pkg.sv - opcodes, constants and FSM encodings shared by the accumulator
package eval_pkg;

    localparam logic [1:0] OP_CLEAR  = 2'd0;
    localparam logic [1:0] OP_ACC    = 2'd1;
    localparam logic [1:0] OP_RD_SUM = 2'd2;
    localparam logic [1:0] OP_RD_CNT = 2'd3;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC_WAIT,
        S_DRAIN,
        S_FLUSH,
        S_RESP
    } fe_state_t;

    typedef enum logic {
        D_IDLE,
        D_ADD
    } dr_state_t;

endpackage

// File: rtl/eval_accumulate_if.sv
// rtl/eval_accumulate_if.sv - custom-instruction request/response bundle
interface eval_accumulate_if;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;

    modport master (output start, n, dataa, input done, result);
    modport slave  (input start, n, dataa, output done, result);
endinterface

// File: rtl/acc_fifo.sv
// rtl/acc_fifo.sv - operand queue with push/pop/flush; pointers carry a wrap bit
module acc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clk_en,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clk_en) begin
            if (flush_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push_i) wptr_q <= wptr_q + 1'b1;
                if (pop_i)  rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clk_en && push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
endmodule

// File: rtl/new_add.sv
// rtl/new_add.sv - multi-cycle single-precision adder, round-to-nearest-even, start/done handshake
module new_add #(
    parameter int LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start_i,
    input  logic [31:0] dataa_i,
    input  logic [31:0] datab_i,
    output logic        done_o,
    output logic [31:0] result_o
);
    localparam int CW = $clog2(LATENCY + 1);

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, r;
        logic [26:0] sx, sy;
        logic [27:0] s;
        logic        st;
        int          ex, ey, d, e;
        if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a | 32'h0040_0000;
        if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b | 32'h0040_0000;
        if (a[30:23] == 8'hFF) begin
            if (b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC0_0000;
            return a;
        end
        if (b[30:23] == 8'hFF) return b;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if (ex == 0) ex = 1;
        if (ey == 0) ey = 1;
        // three extra bits below the mantissa hold guard, round and sticky
        sx = {|x[30:23], x[22:0], 3'b000};
        sy = {|y[30:23], y[22:0], 3'b000};
        d  = ex - ey;
        if (d > 26) begin
            sy = {26'd0, |sy};
        end else begin
            st = |(sy & ((27'd1 << d) - 27'd1));
            sy = (sy >> d) | {26'd0, st};
        end
        e = ex;
        if (x[31] == y[31]) s = {1'b0, sx} + {1'b0, sy};
        else                s = {1'b0, sx} - {1'b0, sy};
        if (s == 28'd0) return 32'h0000_0000;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!s[26] && e > 1) begin
                s = s << 1;
                e = e - 1;
            end
        end
        if (!s[26]) e = 0;
        if (e >= 255) return {x[31], 8'hFF, 23'd0};
        r = {x[31], e[7:0], s[25:3]};
        if (s[2] && (s[1] | s[0] | s[3])) r = r + 32'd1;
        return r;
    endfunction

    logic [CW-1:0] cnt_q;
    logic          busy_q, done_q;
    logic [31:0]   res_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= 32'd0;
        end else if (clk_en) begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                res_q  <= fp_add(dataa_i, datab_i);
                busy_q <= 1'b1;
                cnt_q  <= CW'(LATENCY - 1);
            end else if (busy_q) begin
                if (cnt_q == '0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign done_o   = done_q;
    assign result_o = res_q;
endmodule

// File: rtl/eval_accumulate.sv
// rtl/eval_accumulate.sv - running float sum custom instruction: front-end FSM, operand queue, drain FSM
module eval_accumulate
    import eval_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int ADD_LAT    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clk_en,
    eval_accumulate_if.slave bus
);
    fe_state_t        st_q, st_d;
    dr_state_t        dst_q, dst_d;
    logic [31:0]      sum_q, sum_d, result_q, result_d, hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             push, pop, flush, full, empty, add_done, acc_req, acc_go;
    logic [31:0]      head, push_data, add_res;

    acc_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clk_en  (clk_en),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (push_data),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    new_add #(.LATENCY(ADD_LAT)) u_add (
        .clock    (clock),
        .reset    (reset),
        .clk_en   (clk_en),
        .start_i  (pop),
        .dataa_i  (sum_q),
        .datab_i  (head),
        .done_o   (add_done),
        .result_o (add_res)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q     <= S_IDLE;
            dst_q    <= D_IDLE;
            sum_q    <= FP_ZERO;
            result_q <= FP_ZERO;
            hold_q   <= 32'd0;
            cnt_q    <= '0;
        end else if (clk_en) begin
            st_q     <= st_d;
            dst_q    <= dst_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
        end
    end

    // Drain side: one add at a time, never while a CLEAR is flushing.
    always_comb begin
        pop   = (dst_q == D_IDLE) && !empty && (st_q != S_FLUSH);
        dst_d = dst_q;
        if (pop)                              dst_d = D_ADD;
        else if (dst_q == D_ADD && add_done)  dst_d = D_IDLE;
    end

    assign cnt_inc   = cnt_q + 1'b1;
    assign push_data = (st_q == S_IDLE) ? bus.dataa : hold_q;
    assign acc_req   = (st_q == S_IDLE && bus.start && bus.n == OP_ACC) || (st_q == S_ACC_WAIT);
    assign acc_go    = acc_req && (!full || pop);

    always_comb begin
        st_d     = st_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        hold_d   = hold_q;
        push     = 1'b0;
        flush    = 1'b0;
        // an add finishing during a flush is dropped on the floor
        if (dst_q == D_ADD && add_done && st_q != S_FLUSH) sum_d = add_res;
        case (st_q)
            S_IDLE: if (bus.start) begin
                hold_d = bus.dataa;
                case (bus.n)
                    OP_ACC:    st_d = S_ACC_WAIT;
                    OP_RD_SUM: st_d = S_DRAIN;
                    OP_RD_CNT: begin
                        result_d = 32'(cnt_q);
                        st_d     = S_RESP;
                    end
                    default:   st_d = S_FLUSH;
                endcase
            end
            S_DRAIN: if (empty && dst_q == D_IDLE) begin
                result_d = sum_q;
                st_d     = S_RESP;
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (dst_q == D_IDLE) begin
                    sum_d    = FP_ZERO;
                    cnt_d    = '0;
                    result_d = FP_ZERO;
                    st_d     = S_RESP;
                end
            end
            S_RESP:  st_d = S_IDLE;
            default: ;
        endcase
        if (acc_go) begin
            push     = 1'b1;
            cnt_d    = cnt_inc;
            result_d = 32'(cnt_inc);
            st_d     = S_RESP;
        end
    end

    always_comb begin
        bus.done   = (st_q == S_RESP);
        bus.result = result_q;
    end
endmodule

// File: tb/tb_eval_accumulate.sv
// tb/tb_eval_accumulate.sv - directed bench with a real-valued reference model of the accumulator
module tb_eval_accumulate;
    import eval_pkg::*;

    localparam int CNT_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clk_en = 1'b1;
    eval_accumulate_if bus ();

    eval_accumulate #(.FIFO_DEPTH(4), .CNT_W(CNT_W), .ADD_LAT(16)) dut (
        .clock  (clock),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    real         m_sum = 0.0;
    int          m_cnt = 0;
    int          issued = 0, seen = 0, vectors = 0, miscompares = 0, wait_cnt = 0, exp_lat = -1;
    logic [31:0] exp_res = 32'd0, lit_val = 32'd0;
    logic        has_lit = 1'b0, prev_done = 1'b0, rst_edge = 1'b0, en_edge = 1'b0;
    string       exp_name = "none";

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real  m;
        int   e;
        logic s;
        if (r == 0.0) return 32'd0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    always @(posedge clock) begin
        rst_edge <= reset;
        en_edge  <= clk_en;
    end

    always @(negedge clock) begin
        if (rst_edge) begin
            vectors++;
            if (bus.done !== 1'b0 || bus.result !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_state done=%b result=%h required done=0 result=00000000", bus.done, bus.result);
            end
            seen = issued;
            wait_cnt = 0;
            prev_done = 1'b0;
        end else if (en_edge) begin
            if (bus.done === 1'b1) begin
                vectors++;
                if (prev_done) begin
                    miscompares++;
                    $display("FAIL done_back_to_back done=1 required done=0 after a done cycle");
                end else if (issued == seen) begin
                    miscompares++;
                    $display("FAIL spurious_done done=1 result=%h required done=0 (no request)", bus.result);
                end else begin
                    if (bus.result !== exp_res) begin
                        miscompares++;
                        $display("FAIL %s model result=%h required %h", exp_name, bus.result, exp_res);
                    end
                    if (has_lit) begin
                        vectors++;
                        if (bus.result !== lit_val) begin
                            miscompares++;
                            $display("FAIL %s literal result=%h required %h", exp_name, bus.result, lit_val);
                        end
                    end
                    if (exp_lat != -1) begin
                        vectors++;
                        if ((exp_lat == -2) ? (wait_cnt < 2) : (wait_cnt != exp_lat)) begin
                            miscompares++;
                            $display("FAIL %s latency=%0d required %0d (-2 means >1)", exp_name, wait_cnt, exp_lat);
                        end
                    end
                    seen++;
                end
                wait_cnt = 0;
            end else if (issued != seen) begin
                wait_cnt++;
                if (wait_cnt > 400) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL %s timeout done=0 after %0d cycles required done=1", exp_name, wait_cnt);
                    seen = issued;
                    wait_cnt = 0;
                end
            end
            prev_done = (bus.done === 1'b1);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] d, input int lat,
                         input logic lit_en, input logic [31:0] lit, input string name);
        logic [31:0] e;
        case (op)
            OP_CLEAR:  begin m_sum = 0.0; m_cnt = 0; e = 32'd0; end
            OP_ACC:    begin m_sum = m_sum + f2r(d); m_cnt = (m_cnt + 1) % (1 << CNT_W); e = 32'(m_cnt); end
            OP_RD_SUM: e = r2f(m_sum);
            default:   e = 32'(m_cnt);
        endcase
        @(posedge clock);
        #1;
        bus.start = 1'b1;
        bus.n     = op;
        bus.dataa = d;
        exp_res   = e;
        exp_lat   = lat;
        has_lit   = lit_en;
        lit_val   = lit;
        exp_name  = name;
        issued++;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.dataa = $urandom;
    endtask

    task automatic wait_done();
        int k = 0;
        while (seen != issued && k < 2000) begin
            @(posedge clock);
            k++;
        end
        if (k >= 2000) begin
            $display("FAIL wait_done bench stalled issued=%0d seen=%0d required equal", issued, seen);
            $fatal(1);
        end
    endtask

    task automatic req(input logic [1:0] op, input logic [31:0] d, input int lat,
                       input logic lit_en, input logic [31:0] lit, input string name);
        issue(op, d, lat, lit_en, lit, name);
        wait_done();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.n     = 2'd0;
        bus.dataa = 32'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        req(OP_RD_SUM, 32'd0, 2, 1'b1, 32'h0000_0000, "t1_read_sum");
        req(OP_RD_CNT, 32'd0, 1, 1'b1, 32'd0, "t1_read_cnt");

        req(OP_ACC, 32'h3F80_0000, 1, 1'b1, 32'd1, "t2_acc1");
        req(OP_ACC, 32'h4000_0000, 1, 1'b1, 32'd2, "t2_acc2");
        req(OP_ACC, 32'h4040_0000, 1, 1'b1, 32'd3, "t2_acc3");
        req(OP_RD_SUM, 32'd0, -1, 1'b1, 32'h40C0_0000, "t2_read_sum");
        req(OP_RD_CNT, 32'd0, 1, 1'b1, 32'd3, "t2_read_cnt");

        req(OP_CLEAR, 32'd0, -1, 1'b1, 32'd0, "t3_clear");
        req(OP_ACC, 32'h3F00_0000, 1, 1'b0, 32'd0, "t3_acc1");
        req(OP_ACC, 32'h3FC0_0000, 1, 1'b0, 32'd0, "t3_acc2");
        req(OP_ACC, 32'h4010_0000, 1, 1'b0, 32'd0, "t3_acc3");
        req(OP_ACC, 32'h4080_0000, 1, 1'b0, 32'd0, "t3_acc4");
        req(OP_ACC, 32'h3E80_0000, 1, 1'b0, 32'd0, "t3_acc5");
        req(OP_ACC, 32'h4100_0000, -2, 1'b1, 32'd6, "t3_acc6_full");
        req(OP_RD_SUM, 32'd0, -1, 1'b1, 32'h4184_0000, "t3_read_sum");
        req(OP_RD_CNT, 32'd0, 1, 1'b1, 32'd6, "t3_read_cnt");

        req(OP_CLEAR, 32'd0, -1, 1'b1, 32'd0, "t4_clear0");
        req(OP_ACC, 32'h3F80_0000, 1, 1'b1, 32'd1, "t4_acc1");
        req(OP_ACC, 32'h3F80_0000, 1, 1'b1, 32'd2, "t4_acc2");
        req(OP_CLEAR, 32'd0, -2, 1'b1, 32'd0, "t4_clear_inflight");
        req(OP_RD_SUM, 32'd0, 2, 1'b1, 32'd0, "t4_read_sum");
        req(OP_RD_CNT, 32'd0, 1, 1'b1, 32'd0, "t4_read_cnt");
        repeat (40) @(posedge clock);
        req(OP_RD_SUM, 32'd0, 2, 1'b1, 32'd0, "t4_read_sum_late");

        for (int i = 0; i < 16; i++) req(OP_ACC, 32'h3F80_0000, -1, 1'b0, 32'd0, "t5_acc");
        req(OP_RD_SUM, 32'd0, -1, 1'b1, 32'h4180_0000, "t5_read_sum");
        req(OP_RD_CNT, 32'd0, 1, 1'b1, 32'd0, "t5_read_cnt_wrap");

        req(OP_CLEAR, 32'd0, -1, 1'b1, 32'd0, "t6_clear");
        req(OP_ACC, 32'h4020_0000, -1, 1'b0, 32'd0, "t6_acc1");
        req(OP_ACC, 32'h3F00_0000, -1, 1'b0, 32'd0, "t6_acc2");
        req(OP_ACC, 32'hBF80_0000, -1, 1'b0, 32'd0, "t6_acc3");
        req(OP_ACC, 32'h4020_0000, -1, 1'b0, 32'd0, "t6_acc4");
        issue(OP_RD_SUM, 32'd0, -1, 1'b1, 32'h4090_0000, "t6_read_sum_frozen");
        repeat (3) @(posedge clock);
        #1 clk_en = 1'b0;
        repeat (7) @(posedge clock);
        #1 clk_en = 1'b1;
        wait_done();
        req(OP_RD_CNT, 32'd0, 1, 1'b1, 32'd4, "t6_read_cnt");

        req(OP_ACC, 32'h4100_0000, -1, 1'b0, 32'd0, "t6_acc5");
        req(OP_ACC, 32'h4100_0000, -1, 1'b0, 32'd0, "t6_acc6");
        issue(OP_RD_SUM, 32'd0, -1, 1'b0, 32'd0, "t6_read_sum_reset");
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        m_sum = 0.0;
        m_cnt = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (40) @(posedge clock);
        req(OP_RD_SUM, 32'd0, 2, 1'b1, 32'd0, "t6_read_sum_after_reset");
        req(OP_RD_CNT, 32'd0, 1, 1'b1, 32'd0, "t6_read_cnt_after_reset");

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
